// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, error codes,
// well-known command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Odd parity: the parity bit makes the count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between game logic and the PS/2 host transmitter.
//   tx_valid/tx_data : byte offered by the master
//   tx_ready/busy    : transmitter idle / transfer in progress
//   done/err         : one-cycle completion pulses
//   err_code         : failure cause, held until the next accepted byte
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_line_filter.sv
// PS/2 clock line conditioner: 2-flop synchronizer followed by a
// FILTER_LEN consecutive-sample debounce, with a one-cycle fall pulse.
//   clk, rst : system clock, async active-high reset
//   line_in  : raw pin level
//   level    : filtered level (idles high)
//   fall     : one-cycle pulse when level goes 1 -> 0
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic                  sync1;
  logic                  sync2;
  logic [FILTER_LEN-2:0] hist;
  logic [FILTER_LEN-1:0] window;

  // The live synchronized sample is part of the window, so a level change
  // is accepted on the same edge the FILTER_LEN-th equal sample appears.
  assign window = {hist, sync2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      hist  <= window[FILTER_LEN-2:0];
      fall  <= 1'b0;
      if (&window) begin
        level <= 1'b1;
      end else if (~|window && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit,
// shifts out 8 data bits LSB first plus odd parity on device clock falls,
// releases for the stop bit and checks the device ACK.
//   clk, rst              : 25 MHz system clock, async active-high reset
//   bus                   : command handshake (slave side)
//   ps2_clk_in/data_in    : raw open-drain pin levels
//   ps2_clk_oe/data_oe    : 1 pulls the corresponding pin low
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  import ps2_pkg::*;

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  ps2_tx_state_t    state;
  logic [INH_W-1:0] inh_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             ack_ok;
  logic             tx_ready_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             clk_level;
  logic             clk_fall;
  logic             data_s1;
  logic             data_s2;
  logic             bit_val;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  // Bits 0..7 are payload, bit 8 is parity.
  assign bit_val = bit_cnt[3] ? parity_q : data_q[bit_cnt[2:0]];

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = ~tx_ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      bit_cnt     <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      ack_ok      <= 1'b0;
      tx_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Watchdog expiry outranks any line event in the same cycle.
      if ((state inside {ST_BITS, ST_ACK, ST_WAIT_IDLE}) && wd_cnt == WD_LIMIT) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        err_q       <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
        tx_ready_q  <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.tx_valid && tx_ready_q) begin
              data_q      <= bus.tx_data;
              parity_q    <= odd_parity(bus.tx_data);
              err_code_q  <= ERR_NONE;
              tx_ready_q  <= 1'b0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              inh_cnt     <= '0;
              state       <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;
              wd_cnt      <= '0;
              bit_cnt     <= '0;
              state       <= ST_BITS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          ST_BITS: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (clk_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= ST_ACK;
              end else begin
                ps2_data_oe <= ~bit_val;
              end
            end
          end
          ST_ACK: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (clk_fall) begin
              ack_ok <= ~data_s2;
              state  <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            wd_cnt <= wd_cnt + 1'b1;
            if (clk_level && data_s2) begin
              tx_ready_q <= 1'b1;
              state      <= ST_IDLE;
              if (ack_ok) begin
                done_q <= 1'b1;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_NACK;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain line model and a
// behavioural PS/2 device that clocks frames with randomized half-periods.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 200;
  localparam int unsigned TMO = 4000;
  localparam int unsigned FLT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line;
  logic data_line;

  always #20 clk = ~clk;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int unsigned n_tests  = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt  = 0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line image of a frame: [7:0] payload LSB first, [8] odd parity, [9] stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic send(input logic [7:0] b);
    check_eq("ready_before_send", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    tick();
    bus.tx_valid = 1'b0;
    check_eq("accept_to_clk_oe", ps2_clk_oe, 1);
  endtask

  task automatic measure_inhibit();
    int unsigned n;
    n = 0;
    while (ps2_clk_oe && n < INH + 20) begin
      tick();
      n++;
    end
    check_eq("inhibit_len", n, INH);
    check_eq("start_bit", ps2_data_oe, 1);
  endtask

  // One device clock pulse; data is sampled 8 cycles into the low phase,
  // which also bounds the host's fall-to-data latency.
  task automatic dev_pulse(input int unsigned half, output logic bv);
    dev_clk_low = 1'b1;
    repeat (8) tick();
    bv = data_line;
    repeat (half - 8) tick();
    dev_clk_low = 1'b0;
    repeat (half) tick();
  endtask

  // mode 0: ACK, mode 1: NACK, mode 2: ACK with clock glitch and tx_valid while busy
  task automatic run_frame(input logic [7:0] b, input int unsigned mode);
    logic [9:0]  got;
    logic        bv;
    int unsigned half, d0, e0, n, stray;
    half = $urandom_range(40, 20);
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    measure_inhibit();
    repeat ($urandom_range(30, 12)) tick();
    if (mode == 2) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = ~b;
      dev_clk_low  = 1'b1;
      tick();
      tick();
      dev_clk_low = 1'b0;
      repeat (12) tick();
      check_eq("glitch_no_advance", ps2_data_oe, 1);
      check_eq("busy_during_frame", bus.busy, 1);
    end
    for (int k = 0; k < 10; k++) begin
      dev_pulse(half, bv);
      got[k] = bv;
    end
    bus.tx_valid = 1'b0;
    check_eq("frame_bits", got, exp_frame(b));
    if (mode != 1) dev_data_low = 1'b1;
    repeat (4) tick();
    dev_pulse(half, bv);
    dev_data_low = 1'b0;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check_eq("done_pulses", done_cnt - d0, (mode == 1) ? 0 : 1);
    check_eq("err_pulses", err_cnt - e0, (mode == 1) ? 1 : 0);
    check_eq("err_code", bus.err_code, (mode == 1) ? ERR_NACK : ERR_NONE);
    check_eq("ready_after", bus.tx_ready, 1);
    check_eq("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    if (mode == 2) begin
      stray = 0;
      repeat (20) begin
        tick();
        if (ps2_clk_oe) stray++;
      end
      check_eq("busy_byte_ignored", stray, 0);
    end
  endtask

  task automatic timeout_test();
    int unsigned n, e0;
    e0 = err_cnt;
    send(8'($urandom));
    measure_inhibit();
    n = 0;
    while (!bus.err && n < TMO + 50) begin
      tick();
      n++;
    end
    check_eq("timeout_latency", n, TMO + 1);
    check_eq("timeout_code", bus.err_code, ERR_TIMEOUT);
    check_eq("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check_eq("timeout_ready", bus.tx_ready, 1);
    tick();
    check_eq("timeout_err_once", err_cnt - e0, 1);
  endtask

  task automatic reset_test();
    logic [7:0] b;
    logic       bv;
    b = 8'($urandom) & 8'hEF;
    send(b);
    measure_inhibit();
    repeat (15) tick();
    for (int k = 0; k < 4; k++) dev_pulse(25, bv);
    dev_clk_low = 1'b1;
    repeat (8) tick();
    check_eq("bit4_driven", ps2_data_oe, 1);
    #5 rst = 1'b1;
    #1;
    check_eq("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ready", bus.tx_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_err_code", bus.err_code, ERR_NONE);
    repeat (10) tick();
    check_eq("rst_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("reset_clk_oe", ps2_clk_oe, 0);
    check_eq("reset_data_oe", ps2_data_oe, 0);
    check_eq("reset_ready", bus.tx_ready, 1);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done_err", {bus.done, bus.err}, 0);
    check_eq("reset_err_code", bus.err_code, ERR_NONE);
    rst = 1'b0;
    repeat (2) tick();

    run_frame(PS2_CMD_SET_LEDS, 0);
    run_frame(8'h00, 0);
    run_frame(8'h01, 0);
    run_frame(PS2_CMD_RESET, 0);
    for (int i = 0; i < 3; i++) run_frame(8'($urandom), 0);
    run_frame(8'($urandom), 1);
    timeout_test();
    reset_test();
    run_frame(8'($urandom) | 8'h01, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the game logic to the keyboard. It is the outbound counterpart of the keyboard receive path. It shares the PS2_CLK/PS2_DATA open-drain pins, which the top level drives low when the corresponding `*_oe` output is 1 and releases (z) otherwise. It runs on the 25 MHz system clock.

## Interface
Parameters:
- INHIBIT_CYCLES, default 2500: duration the host holds PS2_CLK low before the start bit (100 µs at 25 MHz).
- TIMEOUT_CYCLES, default 375000: watchdog limit measured from clock release to the end of ACK (15 ms).
- FILTER_LEN, default 4: number of consecutive equal synchronized samples needed to accept a PS2_CLK level.

Ports:
- clk, in, 1: system clock, 25 MHz.
- rst, in, 1: asynchronous, active-high reset.
- tx_valid, in, 1: a command byte is offered.
- tx_data, in, 8: command byte.
- tx_ready, out, 1: block is idle and can accept a byte.
- busy, out, 1: equals !tx_ready. The receive path ignores frames while busy is 1.
- ps2_clk_in, in, 1: raw PS2_CLK pin level.
- ps2_data_in, in, 1: raw PS2_DATA pin level.
- ps2_clk_oe, out, 1: 1 pulls PS2_CLK low.
- ps2_data_oe, out, 1: 1 pulls PS2_DATA low.
- done, out, 1: one-cycle pulse when the device ACKs the byte.
- err, out, 1: one-cycle pulse when the transfer fails.
- err_code, out, 2: failure cause. 01 = NACK, 10 = timeout. Holds its value until the next accepted byte.

## Operation
- Handshake: a byte is accepted when tx_valid && tx_ready on a clk edge. tx_data is latched and parity is computed as ~^tx_data (odd parity). tx_valid is ignored while busy.
- Clock edge detection: ps2_clk_in passes through a 2-flop synchronizer, then the FILTER_LEN filter. A "fall" is the filtered level changing 1→0. ps2_data_in passes through a 2-flop synchronizer only.
- State machine:
  - IDLE: both oe = 0. Accepting a byte moves to INHIBIT. A device-to-host frame already in progress is overridden; the host has priority.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles. Then data_oe = 1 (start bit), clk_oe = 0, and the watchdog is cleared. Move to BITS.
  - BITS: bit counter 0..9. On each fall, data_oe = !bit, where bits 0–7 are tx_data LSB first and bit 8 is parity. On the fall for bit 9 (stop), data_oe = 0 and move to ACK.
  - ACK: on the next fall, sample data. Data 0 moves to WAIT_IDLE with ack_ok. Data 1 moves to WAIT_IDLE with a NACK.
  - WAIT_IDLE: wait until the filtered clock and synchronized data are both 1. Then pulse done (ack_ok) or err with err_code=01 (NACK), and return to IDLE.
- Watchdog: counts from clock release. At TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE, release both oe, pulse err with err_code=10, and go to IDLE.
- Reset: rst asynchronously forces IDLE and clears the counters. Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, done = 0, err = 0, err_code = 00.

## Timing
- Acceptance to clk_oe = 1: 1 cycle (registered).
- clk_oe low window: exactly INHIBIT_CYCLES cycles. data_oe rises in the same cycle that clk_oe falls.
- Device fall to data_oe update: at most 2 + FILTER_LEN + 1 = 7 cycles (280 ns). This is far inside the ≥30 µs device half-period.
- done/err: registered, asserted 1 cycle after the IDLE condition is detected in WAIT_IDLE.
- tx_ready rises in the same cycle as done/err. A new byte may be accepted in that cycle.
- Simultaneous events:
  - A watchdog expiry in the same cycle as the final fall takes priority, giving a timeout.
  - rst overrides everything.

## Structure
- Shared package ps2_pkg holds:
  - the state encoding;
  - err codes ERR_NONE = 2'b00, ERR_NACK = 2'b01, ERR_TIMEOUT = 2'b10;
  - command constants PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_RESP_ACK = 8'hFA.
- One sub-module, ps2_line_filter: synchronizer, FILTER_LEN filter and fall-pulse output. It is reusable by the receive path.
- Counter widths are $clog2 of their parameter; the bit counter is 4 bits.

## Test plan
- Send 0xED; the device model clocks at 12 kHz and ACKs.
  - Required: clk_oe high for 2500 cycles.
  - Data on the line: 1,0,1,1,0,1,1,1, then parity 1, then stop.
  - Required: one done pulse, err_code = 00, tx_ready = 1 afterwards.
- Send 0x00 and 0x01.
  - Required: parity bit 1 for 0x00 and 0 for 0x01.
  - Both complete with done.
- Device leaves data high at the ACK clock.
  - Required: err pulse with err_code = 01, then IDLE once the lines are released.
- Device never clocks after the start bit.
  - Required: err with err_code = 10 exactly TIMEOUT_CYCLES + 1 cycles after clock release, both oe = 0.
- Assert rst during bit 4.
  - Required: both oe = 0 immediately (asynchronous), tx_ready = 1 and err_code = 00 after release.
- Inject a 2-cycle low glitch on ps2_clk_in; assert tx_valid while busy.
  - Required: no bit advance from the glitch, and the second byte is not accepted.
